// File: rtl/riscv_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory port.
// At most one memory transaction is outstanding. Data wins ties unless the
// fetch side has waited STARVE_LIMIT data grants. A presented but ungranted
// request stays locked to its master until the memory accepts it.
module riscv_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch master
    input  logic        i_ireq,
    input  logic [31:0] i_iaddr,
    output logic        o_igrant,
    output logic        o_irvalid,
    output logic [31:0] o_irdata,
    // data master
    input  logic        i_dreq,
    input  logic        i_dwe,
    input  logic [3:0]  i_dbe,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dwdata,
    output logic        o_dgrant,
    output logic        o_drvalid,
    output logic [31:0] o_drdata,
    // memory port
    output logic        o_mreq,
    output logic        o_mwe,
    output logic [3:0]  o_mbe,
    output logic [31:0] o_maddr,
    output logic [31:0] o_mwdata,
    input  logic        i_mgrant,
    input  logic        i_mrvalid,
    input  logic [31:0] i_mrdata,
    // sticky protocol error
    output logic        o_proto_err
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          lock_q, lock_d;
    logic          lock_data_q, lock_data_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          proto_err_q, proto_err_d;

    logic idle;
    logic sel_data;

    // Master selection: honour a live lock, else data first unless fetch is starved
    always_comb begin
        idle     = rst_n && (state_q == IDLE);
        sel_data = 1'b0;
        if (lock_q && (lock_data_q ? i_dreq : i_ireq)) begin
            sel_data = lock_data_q;
        end else if (i_ireq && i_dreq) begin
            sel_data = (starve_q != STARVE_MAX);
        end else begin
            sel_data = i_dreq;
        end
    end

    // Combinational request/grant/response outputs, all forced low in reset
    always_comb begin
        o_mreq    = idle && (i_ireq || i_dreq);
        o_dgrant  = o_mreq && sel_data && i_mgrant;
        o_igrant  = o_mreq && !sel_data && i_mgrant;
        o_mwe     = 1'b0;
        o_mbe     = 4'h0;
        o_maddr   = 32'h0;
        o_mwdata  = 32'h0;
        if (o_mreq) begin
            if (sel_data) begin
                o_mwe    = i_dwe;
                o_mbe    = i_dbe;
                o_maddr  = i_daddr;
                o_mwdata = i_dwdata;
            end else begin
                o_mbe    = 4'hF;
                o_maddr  = i_iaddr;
            end
        end
        o_irvalid   = rst_n && (state_q == RESP_I) && i_mrvalid;
        o_drvalid   = rst_n && (state_q == RESP_D) && i_mrvalid;
        o_irdata    = o_irvalid ? i_mrdata : 32'h0;
        o_drdata    = o_drvalid ? i_mrdata : 32'h0;
        o_proto_err = proto_err_q;
    end

    // Next-state: transaction sequencing, lock, starvation count, error flag
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        lock_data_d = lock_data_q;
        starve_d    = starve_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (i_mrvalid) begin
                    proto_err_d = 1'b1;
                end
                if (o_dgrant) begin
                    state_d = RESP_D;
                    lock_d  = 1'b0;
                    if (i_ireq && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (o_igrant) begin
                    state_d  = RESP_I;
                    lock_d   = 1'b0;
                    starve_d = '0;
                end else if (o_mreq) begin
                    lock_d      = 1'b1;
                    lock_data_d = sel_data;
                end
            end
            RESP_I, RESP_D: begin
                if (i_mrvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            lock_data_q <= lock_data_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Bench for riscv_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level arbitration model.
module tb_riscv_bus_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_ireq, i_dreq, i_dwe, i_mgrant, i_mrvalid;
    logic [31:0] i_iaddr, i_daddr, i_dwdata, i_mrdata;
    logic [3:0]  i_dbe;
    logic        o_igrant, o_irvalid, o_dgrant, o_drvalid;
    logic        o_mreq, o_mwe, o_proto_err;
    logic [3:0]  o_mbe;
    logic [31:0] o_irdata, o_drdata, o_maddr, o_mwdata;

    always #5 clk = ~clk;

    riscv_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ireq(i_ireq), .i_iaddr(i_iaddr),
        .o_igrant(o_igrant), .o_irvalid(o_irvalid), .o_irdata(o_irdata),
        .i_dreq(i_dreq), .i_dwe(i_dwe), .i_dbe(i_dbe), .i_daddr(i_daddr), .i_dwdata(i_dwdata),
        .o_dgrant(o_dgrant), .o_drvalid(o_drvalid), .o_drdata(o_drdata),
        .o_mreq(o_mreq), .o_mwe(o_mwe), .o_mbe(o_mbe), .o_maddr(o_maddr), .o_mwdata(o_mwdata),
        .i_mgrant(i_mgrant), .i_mrvalid(i_mrvalid), .i_mrdata(i_mrdata),
        .o_proto_err(o_proto_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: owner of the outstanding transaction (0 none, 1 fetch, 2 data),
    // master currently presented without grant (-1 none, 0 fetch, 1 data),
    // data grants taken while fetch waited, and the sticky error.
    int m_out    = 0;
    int m_pres   = -1;
    int m_starve = 0;
    bit m_perr   = 0;
    int pick;
    bit e_req, e_gi, e_gd;

    // Sample at the falling edge and compare every output against the model
    task automatic settle();
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        logic        ew;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_mreq",   32'(o_mreq),   0);
            chk("rst_grants", 32'({o_igrant, o_dgrant}), 0);
            chk("rst_rvalid", 32'({o_irvalid, o_drvalid}), 0);
            chk("rst_data",   o_maddr | o_mwdata | o_irdata | o_drdata | 32'(o_mbe) | 32'(o_mwe), 0);
            chk("rst_perr",   32'(o_proto_err), 0);
            e_req = 0; e_gi = 0; e_gd = 0;
            return;
        end
        e_req = 0; e_gi = 0; e_gd = 0; pick = 0;
        if (m_out == 0 && (i_ireq || i_dreq)) begin
            e_req = 1;
            if (m_pres >= 0 && (m_pres == 1 ? i_dreq : i_ireq)) pick = m_pres;
            else if (i_ireq && i_dreq) pick = (m_starve == LIMIT) ? 0 : 1;
            else pick = i_dreq ? 1 : 0;
            e_gi = i_mgrant && pick == 0;
            e_gd = i_mgrant && pick == 1;
        end
        ea = !e_req ? 32'h0 : (pick == 1 ? i_daddr : i_iaddr);
        ed = (e_req && pick == 1) ? i_dwdata : 32'h0;
        eb = !e_req ? 4'h0 : (pick == 1 ? i_dbe : 4'hF);
        ew = e_req && pick == 1 && i_dwe;
        chk("mreq",    32'(o_mreq),   32'(e_req));
        chk("igrant",  32'(o_igrant), 32'(e_gi));
        chk("dgrant",  32'(o_dgrant), 32'(e_gd));
        chk("maddr",   o_maddr, ea);
        chk("mwdata",  o_mwdata, ed);
        chk("mbe_mwe", 32'({o_mwe, o_mbe}), 32'({ew, eb}));
        chk("irvalid", 32'(o_irvalid), 32'(m_out == 1 && i_mrvalid));
        chk("irdata",  o_irdata, (m_out == 1 && i_mrvalid) ? i_mrdata : 32'h0);
        chk("drvalid", 32'(o_drvalid), 32'(m_out == 2 && i_mrvalid));
        chk("drdata",  o_drdata, (m_out == 2 && i_mrvalid) ? i_mrdata : 32'h0);
        chk("perr",    32'(o_proto_err), 32'(m_perr));
    endtask

    // Advance the model with this cycle's inputs, then move to just after the edge
    task automatic advance();
        if (!rst_n) begin
            m_out = 0; m_pres = -1; m_starve = 0; m_perr = 0;
        end else if (m_out != 0) begin
            if (i_mrvalid) m_out = 0;
        end else begin
            if (i_mrvalid) m_perr = 1;
            if (e_gd) begin
                m_out = 2; m_pres = -1;
                if (i_ireq && m_starve < LIMIT) m_starve++;
            end else if (e_gi) begin
                m_out = 1; m_pres = -1; m_starve = 0;
            end else if (e_req) begin
                m_pres = pick;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ireq = 0; i_dreq = 0; i_dwe = 0; i_mgrant = 0; i_mrvalid = 0;
        i_dbe = 4'h0; i_iaddr = 0; i_daddr = 0; i_dwdata = 0; i_mrdata = 0;
    endtask

    initial begin
        int ndata;
        bit gi, gd;
        rst_n = 1'b0;
        idle_inputs();
        settle(); advance();
        settle(); advance();
        rst_n = 1'b1;

        // Single fetch with a one-cycle response gap
        i_ireq = 1; i_iaddr = 32'h80; i_mgrant = 1;
        settle();
        chk("fetch_igrant", 32'(o_igrant), 1);
        chk("fetch_maddr", o_maddr, 32'h80);
        advance();
        i_ireq = 0; i_mgrant = 0;
        settle(); advance();
        i_mrvalid = 1; i_mrdata = 32'h0050_0093;
        settle();
        chk("fetch_irvalid", 32'(o_irvalid), 1);
        chk("fetch_irdata", o_irdata, 32'h0050_0093);
        advance();
        i_mrvalid = 0;

        // Simultaneous requests: data first, fetch at the next idle cycle
        i_ireq = 1; i_iaddr = 32'h2000; i_dreq = 1; i_daddr = 32'h1000; i_mgrant = 1;
        settle();
        chk("both_dgrant", 32'(o_dgrant), 1);
        chk("both_maddr", o_maddr, 32'h1000);
        advance();
        i_dreq = 0; i_mrvalid = 1; i_mrdata = 32'h1111;
        settle(); advance();
        i_mrvalid = 0;
        settle();
        chk("both_igrant", 32'(o_igrant), 1);
        chk("both_maddr2", o_maddr, 32'h2000);
        advance();
        i_ireq = 0; i_mrvalid = 1;
        settle(); advance();

        // Starvation: both held, count data grants before the fetch wins
        ndata = 0;
        gi = 0;
        for (int k = 0; k < 12 && !gi; k++) begin
            i_ireq = 1; i_dreq = 1; i_mgrant = 1; i_mrvalid = 0;
            settle();
            gi = o_igrant;
            if (o_dgrant) ndata++;
            advance();
            i_mgrant = 0; i_mrvalid = 1;
            settle(); advance();
        end
        chk("starve_igrant_seen", 32'(gi), 1);
        chk("starve_data_grants", 32'(ndata), LIMIT);
        i_mrvalid = 0; i_mgrant = 1;
        settle();
        chk("starve_cleared", 32'(o_dgrant), 1);
        advance();
        i_ireq = 0; i_dreq = 0; i_mgrant = 0; i_mrvalid = 1;
        settle(); advance();
        i_mrvalid = 0;

        // Lock: data presented without grant while fetch rises
        i_dreq = 1; i_daddr = 32'h3000; i_iaddr = 32'h4000;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("lock_maddr", o_maddr, 32'h3000);
            advance();
            i_ireq = 1;
        end
        i_mgrant = 1;
        settle();
        chk("lock_dgrant", 32'(o_dgrant), 1);
        advance();
        i_dreq = 0; i_ireq = 0; i_mgrant = 0; i_mrvalid = 1;
        settle(); advance();
        i_mrvalid = 0;

        // Store
        i_dreq = 1; i_dwe = 1; i_dbe = 4'b0011; i_daddr = 32'h44; i_dwdata = 32'hABCD; i_mgrant = 1;
        settle();
        chk("store_mwe", 32'(o_mwe), 1);
        chk("store_mbe", 32'(o_mbe), 32'h3);
        chk("store_mwdata", o_mwdata, 32'hABCD);
        advance();
        i_dreq = 0; i_dwe = 0; i_mgrant = 0; i_mrvalid = 1; i_mrdata = 32'h5A5A;
        settle();
        chk("store_drvalid", 32'(o_drvalid), 1);
        advance();
        i_mrvalid = 0;

        // Randomized traffic; masters hold requests until granted
        for (int c = 0; c < 3000; c++) begin
            if (!i_ireq && $urandom_range(0, 2) == 0) begin
                i_ireq = 1; i_iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!i_dreq && $urandom_range(0, 2) == 0) begin
                i_dreq = 1; i_dwe = 1'($urandom); i_dbe = 4'($urandom);
                i_daddr = $urandom; i_dwdata = $urandom;
            end
            i_mgrant  = 1'($urandom);
            i_mrvalid = (m_out != 0) && ($urandom_range(0, 1) == 1);
            i_mrdata  = $urandom;
            settle();
            gi = e_gi;
            gd = e_gd;
            advance();
            if (gi) i_ireq = 0;
            if (gd) i_dreq = 0;
        end

        // Drain anything outstanding
        for (int k = 0; k < 3; k++) begin
            i_ireq = 0; i_dreq = 0; i_mgrant = 0; i_mrvalid = (m_out != 0);
            settle(); advance();
        end
        i_mrvalid = 0;

        // Reset during a data transaction, then a stray response
        i_dreq = 1; i_dwe = 0; i_daddr = 32'h900; i_mgrant = 1;
        settle(); advance();
        i_dreq = 0; i_mgrant = 0;
        rst_n = 0;
        settle(); advance();
        rst_n = 1; i_mrvalid = 1; i_mrdata = 32'hDEAD;
        settle();
        chk("rstx_no_drvalid", 32'(o_drvalid), 0);
        advance();
        i_mrvalid = 0;
        settle();
        chk("rstx_proto_err", 32'(o_proto_err), 1);
        advance();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
